framebuffer_scanout: RTL and testbench
======================================

// Module: framebuffer_scanout
// PURPOSE
// Read side of the screen frame buffer. Generates raster timing, issues sequential
// read addresses to the frame-buffer RAM read port, aligns returned 24-bit colour with
// delayed syncs, and outputs a video pixel stream. Owns double-buffer selection:
// swaps the displayed buffer only at vblank, on request from the rasteriser side.
// PARAMETERS
// WIDTH        1024  active pixels per line
// HEIGHT       720   active lines per frame
// H_FP/H_SYNC/H_BP  110/40/220  horizontal porch/sync/porch, in pixels
// V_FP/V_SYNC/V_BP  5/5/20      vertical porch/sync/porch, in lines
// RAM_LATENCY  2     cycles from addr_out to rdata_in valid (registered-output BRAM)
// PORTS
// clk_in        in   1   pixel clock; single clock domain
// rst_in        in   1   asynchronous, active-low reset
// rdata_in      in   24  colour from frame-buffer RAM read port, {R,G,B}
// swap_req_in   in   1   level: back buffer complete, request swap; hold until swap_ack_out
// addr_out      out  $clog2(WIDTH*HEIGHT)  read address, x + y*WIDTH of displayed buffer
// buf_sel_out   out  1   displayed buffer; rasteriser writes to ~buf_sel_out
// swap_ack_out  out  1   one-cycle pulse: swap performed
// rgb_out       out  24  pixel colour; 24'h0 outside active area
// hsync_out     out  1   active-high horizontal sync
// vsync_out     out  1   active-high vertical sync
// active_out    out  1   rgb_out is a visible pixel
// frame_start_out out 1  one-cycle pulse aligned with first active pixel (0,0)
// BEHAVIOUR
// - Reset (rst_in low, any time, async): hcount=vcount=0, addr_out=0, buf_sel_out=0,
//   all other outputs 0, swap FSM IDLE, delay pipes cleared. Resumes at (0,0) on release.
// - hcount 0..H_TOTAL-1 (H_TOTAL=WIDTH+H_FP+H_SYNC+H_BP); wraps to 0, vcount+1;
//   vcount wraps to 0 after V_TOTAL-1. Active: hcount<WIDTH && vcount<HEIGHT.
// - hsync raw = hcount in [WIDTH+H_FP, WIDTH+H_FP+H_SYNC); vsync likewise on vcount.
// - addr_out: incremental counter, no multiplier. +1 per active cycle; holds outside
//   active; reset to 0 at vcount==V_TOTAL-1, hcount==H_TOTAL-1. Never exceeds WIDTH*HEIGHT-1.
// - hsync/vsync/active/frame_start delayed RAM_LATENCY cycles so rgb_out, syncs, active
//   for pixel (x,y) appear together RAM_LATENCY cycles after addr_out=x+y*WIDTH.
// - rgb_out = active_dly ? rdata_in : 24'h0 (registered only if RAM_LATENCY budget permits;
//   total latency addr_out->rgb_out is fixed at RAM_LATENCY).
// - Swap FSM: IDLE -(swap_req_in)-> PENDING -(vblank edge: hcount==0 && vcount==HEIGHT)->
//   ACK (buf_sel_out toggles, swap_ack_out=1 for that cycle) -> WAIT_DROP;
//   WAIT_DROP -(!swap_req_in)-> IDLE. At most one swap per frame.
// - swap_req_in rising on the vblank-edge cycle itself: swap that same edge (IDLE sees
//   req and edge together -> ACK directly).
// - swap_req_in dropped while PENDING: return to IDLE, no swap, no ack.
// - buf_sel_out never changes during active region; rasteriser uses it as write MSB.
// STRUCTURE
// - display_pkg: WIDTH/HEIGHT/porch localparams, H_TOTAL/V_TOTAL, typedef pixel_t
//   (logic [23:0]), typedef swap_state_t {IDLE, PENDING, ACK, WAIT_DROP}.
// - Sub-module video_timing_gen: h/v counters, raw hsync/vsync/active, vblank edge pulse.
// - Top: address counter, RAM_LATENCY delay shift registers, swap FSM, output regs.
// TESTING
// - Reset release, default params: count cycles -> hsync period 1394, vsync period
//   750*1394; hsync high 40 cycles starting 1134 cycles after first active pixel.
// - RAM model returns addr as colour, latency 2 -> rgb_out==addr of pixel at every active
//   cycle; (1023,719) shows 737279; first pixel of next frame shows 0; blanking shows 0.
// - swap_req_in asserted at line 300 -> swap_ack_out at hcount 0, vcount 720 only;
//   buf_sel_out 0->1; no second ack while req held across next vblank.
// - swap_req_in asserted exactly on vblank-edge cycle -> ack same cycle; asserted one cycle
//   after -> ack at next frame's vblank edge.
// - swap_req_in pulsed high then low before vblank -> no ack, buf_sel_out unchanged.
// - rst_in low mid-line (hcount 500, vcount 100) -> outputs 0 immediately (async);
//   after release, frame_start_out pulse 2 cycles after addr_out=0, buf_sel_out=0.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: default raster timing, pixel type and swap FSM states for frame-buffer scanout
package display_pkg;
  localparam int WIDTH = 1024;
  localparam int HEIGHT = 720;
  localparam int H_FP = 110;
  localparam int H_SYNC = 40;
  localparam int H_BP = 220;
  localparam int V_FP = 5;
  localparam int V_SYNC = 5;
  localparam int V_BP = 20;
  localparam int RAM_LATENCY = 2;
  localparam int H_TOTAL = WIDTH + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = HEIGHT + V_FP + V_SYNC + V_BP;
  typedef logic [23:0] pixel_t;
  typedef enum logic [1:0] {IDLE, PENDING, ACK, WAIT_DROP} swap_state_t;
endpackage

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster h/v counters with raw sync, active, frame and vblank-edge strobes
module video_timing_gen import display_pkg::*; #(
  parameter int WIDTH = display_pkg::WIDTH,
  parameter int HEIGHT = display_pkg::HEIGHT,
  parameter int H_FP = display_pkg::H_FP,
  parameter int H_SYNC = display_pkg::H_SYNC,
  parameter int H_BP = display_pkg::H_BP,
  parameter int V_FP = display_pkg::V_FP,
  parameter int V_SYNC = display_pkg::V_SYNC,
  parameter int V_BP = display_pkg::V_BP
) (
  input  logic clk_in,
  input  logic rst_in,
  output logic hsync,
  output logic vsync,
  output logic active,
  output logic frame_start,
  output logic frame_end,
  output logic vblank_edge
);
  localparam int HT = WIDTH + H_FP + H_SYNC + H_BP;
  localparam int VT = HEIGHT + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic h_last, v_last;
  assign h_last = hcount == HW'(HT - 1);
  assign v_last = vcount == VW'(VT - 1);
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      hcount <= '0;
      vcount <= '0;
    end else begin
      hcount <= h_last ? '0 : hcount + 1'b1;
      if (h_last) vcount <= v_last ? '0 : vcount + 1'b1;
    end
  assign hsync = hcount >= HW'(WIDTH + H_FP) && hcount < HW'(WIDTH + H_FP + H_SYNC);
  assign vsync = vcount >= VW'(HEIGHT + V_FP) && vcount < VW'(HEIGHT + V_FP + V_SYNC);
  assign active = hcount < HW'(WIDTH) && vcount < VW'(HEIGHT);
  assign frame_start = hcount == '0 && vcount == '0;
  assign frame_end = h_last && v_last;
  assign vblank_edge = hcount == '0 && vcount == VW'(HEIGHT);
endmodule

// File: rtl/framebuffer_scanout.sv
// framebuffer_scanout: raster scanout of a double-buffered frame buffer with vblank-only swap
module framebuffer_scanout import display_pkg::*; #(
  parameter int WIDTH = display_pkg::WIDTH,
  parameter int HEIGHT = display_pkg::HEIGHT,
  parameter int H_FP = display_pkg::H_FP,
  parameter int H_SYNC = display_pkg::H_SYNC,
  parameter int H_BP = display_pkg::H_BP,
  parameter int V_FP = display_pkg::V_FP,
  parameter int V_SYNC = display_pkg::V_SYNC,
  parameter int V_BP = display_pkg::V_BP,
  parameter int RAM_LATENCY = display_pkg::RAM_LATENCY
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  pixel_t                             rdata_in,
  input  logic                               swap_req_in,
  output logic [$clog2(WIDTH * HEIGHT)-1:0]  addr_out,
  output logic                               buf_sel_out,
  output logic                               swap_ack_out,
  output pixel_t                             rgb_out,
  output logic                               hsync_out,
  output logic                               vsync_out,
  output logic                               active_out,
  output logic                               frame_start_out
);
  localparam int AW = $clog2(WIDTH * HEIGHT);
  localparam logic [AW-1:0] ADDR_MAX = AW'(WIDTH * HEIGHT - 1);
  logic hs, vs, act, fs, f_end, vb_edge, fire;
  logic [3:0] pipe [RAM_LATENCY];
  swap_state_t state, state_nx;
  video_timing_gen #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk_in(clk_in), .rst_in(rst_in), .hsync(hs), .vsync(vs), .active(act),
    .frame_start(fs), .frame_end(f_end), .vblank_edge(vb_edge)
  );
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      addr_out <= '0;
      buf_sel_out <= 1'b0;
      state <= IDLE;
      for (int i = 0; i < RAM_LATENCY; i++) pipe[i] <= '0;
    end else begin
      addr_out <= f_end ? '0 : (act && addr_out != ADDR_MAX) ? addr_out + 1'b1 : addr_out;
      buf_sel_out <= buf_sel_out ^ fire;
      state <= state_nx;
      pipe[0] <= {hs, vs, act, fs};
      for (int i = 1; i < RAM_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  always_comb begin
    state_nx = state;
    fire = 1'b0;
    case (state)
      IDLE, PENDING: begin
        fire = swap_req_in && vb_edge;
        state_nx = fire ? ACK : swap_req_in ? PENDING : IDLE;
      end
      ACK: state_nx = WAIT_DROP;
      WAIT_DROP: state_nx = swap_req_in ? WAIT_DROP : IDLE;
    endcase
  end
  assign swap_ack_out = fire;
  assign {hsync_out, vsync_out, active_out, frame_start_out} = pipe[RAM_LATENCY-1];
  assign rgb_out = active_out ? rdata_in : '0;
endmodule

// File: tb/tb_framebuffer_scanout.sv
// tb_framebuffer_scanout: directed checks of scanout timing, pixel alignment, buffer swap and reset
module tb_framebuffer_scanout;
  localparam int W = 8, H = 6, HFP = 2, HS = 3, HBP = 2, VFP = 1, VS = 2, VBP = 1;
  localparam int HT = W + HFP + HS + HBP, VT = H + VFP + VS + VBP, AW = $clog2(W * H);
  localparam int NV = 21;
  typedef struct {int pos; int addr; int rgb; logic [3:0] sig;} vec_t;
  logic clk_in, rst_in, swap_req_in;
  logic [23:0] rdata_in, rgb_out;
  logic [AW-1:0] addr_out, r1, r2;
  logic buf_sel_out, swap_ack_out, hsync_out, vsync_out, active_out, frame_start_out;
  logic [19:0] d_addr;
  logic [23:0] d_rgb;
  logic d_buf, d_ack, d_hs, d_vs, d_act, d_fs;
  int pos, tests, fails;
  bit model_on;
  vec_t tv [NV];
  framebuffer_scanout #(
    .WIDTH(W), .HEIGHT(H), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .RAM_LATENCY(2)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdata_in(rdata_in), .swap_req_in(swap_req_in),
    .addr_out(addr_out), .buf_sel_out(buf_sel_out), .swap_ack_out(swap_ack_out),
    .rgb_out(rgb_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .active_out(active_out), .frame_start_out(frame_start_out)
  );
  framebuffer_scanout dut_d (
    .clk_in(clk_in), .rst_in(rst_in), .rdata_in(24'h0), .swap_req_in(1'b0),
    .addr_out(d_addr), .buf_sel_out(d_buf), .swap_ack_out(d_ack),
    .rgb_out(d_rgb), .hsync_out(d_hs), .vsync_out(d_vs),
    .active_out(d_act), .frame_start_out(d_fs)
  );
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) begin
    r1 <= addr_out;
    r2 <= r1;
  end
  assign rdata_in = 24'(r2);
  always @(posedge clk_in or negedge rst_in)
    if (!rst_in) pos <= 0;
    else pos <= pos + 1;
  function automatic int exp_addr(int p);
    int h, v, n;
    h = p % HT;
    v = (p / HT) % VT;
    n = (v < H) ? v * W + ((h < W) ? h : W) : W * H;
    return (n > W * H - 1) ? W * H - 1 : n;
  endfunction
  function automatic int exp_rgb(int q);
    int h, v;
    if (q < 0) return 0;
    h = q % HT;
    v = (q / HT) % VT;
    return (h < W && v < H) ? h + v * W : 0;
  endfunction
  function automatic logic [3:0] exp_raw(int q);
    int h, v;
    if (q < 0) return 4'b0000;
    h = q % HT;
    v = (q / HT) % VT;
    return {h >= W + HFP && h < W + HFP + HS, v >= H + VFP && v < H + VFP + VS,
            h < W && v < H, h == 0 && v == 0};
  endfunction
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask
  task automatic check_model();
    int q = pos - 2;
    check($sformatf("stream@%0d", pos),
          64'({addr_out, rgb_out, hsync_out, vsync_out, active_out, frame_start_out}),
          64'({AW'(exp_addr(pos)), 24'(exp_rgb(q)), exp_raw(q)}));
  endtask
  task automatic tick();
    @(negedge clk_in);
    if (model_on) check_model();
  endtask
  initial begin
    int ti, t_act, t_r1, t_r2, t_f1;
    logic hs_prev, d_bad;
    tv[0]  = '{0, 0, 0, 4'b0000};
    tv[1]  = '{1, 1, 0, 4'b0000};
    tv[2]  = '{2, 2, 0, 4'b0011};
    tv[3]  = '{3, 3, 1, 4'b0010};
    tv[4]  = '{9, 8, 7, 4'b0010};
    tv[5]  = '{10, 8, 0, 4'b0000};
    tv[6]  = '{12, 8, 0, 4'b1000};
    tv[7]  = '{14, 8, 0, 4'b1000};
    tv[8]  = '{15, 8, 0, 4'b0000};
    tv[9]  = '{17, 10, 8, 4'b0010};
    tv[10] = '{82, 47, 45, 4'b0010};
    tv[11] = '{84, 47, 47, 4'b0010};
    tv[12] = '{85, 47, 0, 4'b0000};
    tv[13] = '{92, 47, 0, 4'b0000};
    tv[14] = '{107, 47, 0, 4'b0100};
    tv[15] = '{117, 47, 0, 4'b1100};
    tv[16] = '{122, 47, 0, 4'b0100};
    tv[17] = '{137, 47, 0, 4'b0000};
    tv[18] = '{150, 0, 0, 4'b0000};
    tv[19] = '{152, 2, 0, 4'b0011};
    tv[20] = '{153, 3, 1, 4'b0010};
    tests = 0;
    fails = 0;
    model_on = 1'b0;
    swap_req_in = 1'b0;
    rst_in = 1'b1;
    #1 rst_in = 1'b0;
    #1;
    check("reset_state", 64'({addr_out, buf_sel_out, swap_ack_out, rgb_out, hsync_out,
          vsync_out, active_out, frame_start_out}), 64'(0));
    @(posedge clk_in);
    #1 rst_in = 1'b1;
    model_on = 1'b1;
    t_act = -1; t_r1 = -1; t_r2 = -1; t_f1 = -1;
    hs_prev = 1'b0;
    d_bad = 1'b0;
    for (int c = 0; c < 2600; c++) begin
      tick();
      if (d_act && t_act < 0) t_act = pos;
      if (d_hs && !hs_prev) begin
        if (t_r1 < 0) t_r1 = pos;
        else if (t_r2 < 0) t_r2 = pos;
      end
      if (!d_hs && hs_prev && t_f1 < 0) t_f1 = pos;
      hs_prev = d_hs;
      d_bad = d_bad | d_vs | d_buf | d_ack | (|d_rgb);
      if (pos == 2) check("dflt_frame_start", 64'(d_fs), 64'(1));
      if (pos == 1394) check("dflt_addr_line1", 64'(d_addr), 64'(1024));
    end
    check("dflt_hsync_offset", 64'(t_r1 - t_act), 64'(1134));
    check("dflt_hsync_width", 64'(t_f1 - t_r1), 64'(40));
    check("dflt_hsync_period", 64'(t_r2 - t_r1), 64'(1394));
    check("dflt_quiet", 64'(d_bad), 64'(0));
    rst_in = 1'b0;
    @(posedge clk_in);
    #1 rst_in = 1'b1;
    ti = 0;
    for (int p = 0; p < 949; p++) begin
      tick();
      if (ti < NV && tv[ti].pos == pos) begin
        check($sformatf("vec%0d@%0d", ti, pos),
              64'({addr_out, rgb_out, hsync_out, vsync_out, active_out, frame_start_out}),
              64'({AW'(tv[ti].addr), 24'(tv[ti].rgb), tv[ti].sig}));
        ti++;
      end
      swap_req_in = (p >= 45 && p < 300) || (p >= 390 && p < 400) ||
                    (p >= 541 && p < 700) || (p >= 750 && p < 760);
      #1;
      check($sformatf("swap_ack@%0d", p), 64'(swap_ack_out), 64'(p == 90 || p == 390 || p == 690));
      check($sformatf("buf_sel@%0d", p), 64'(buf_sel_out), 64'((p > 90) ^ (p > 390) ^ (p > 690)));
    end
    tick();
    rst_in = 1'b0;
    #1;
    check("async_reset", 64'({addr_out, buf_sel_out, swap_ack_out, rgb_out, hsync_out,
          vsync_out, active_out, frame_start_out}), 64'(0));
    @(posedge clk_in);
    #1 rst_in = 1'b1;
    tick();
    check("post_reset_addr", 64'({addr_out, buf_sel_out}), 64'(0));
    tick();
    tick();
    check("post_reset_frame_start", 64'(frame_start_out), 64'(1));
    repeat (4) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
